// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scan controller: segment decode table,
// dark pattern, handshake states and a counter-width helper.
package seg_scan_ctrl_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'h7F;

  // Active-low {g..a}; element 0 is the rightmost entry (hex 0)
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef enum logic {
    LD_IDLE,
    LD_PEND
  } ld_state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Host/display signal bundle for seg_scan_ctrl; the controller uses the slave view.
interface seg_scan_ctrl_if #(
  parameter int unsigned NDIG = 8
);
  logic [4*NDIG-1:0] data;
  logic [NDIG-1:0]   dig_en;
  logic [NDIG-1:0]   blink;
  logic              lz_en;
  logic              load;
  logic              busy;
  logic              frame;
  logic [NDIG-1:0]   an;
  logic [6:0]        seg;

  modport master (
    output data, dig_en, blink, lz_en, load,
    input  busy, frame, an, seg
  );

  modport slave (
    input  data, dig_en, blink, lz_en, load,
    output busy, frame, an, seg
  );
endinterface

// File: rtl/seg_scan_ctrl_seg_h.sv
// Combinational hex-to-7-segment decoder, active-low outputs; en=0 gives dark.
module seg_h
  import seg_scan_ctrl_pkg::*;
(
  input  logic       en,
  input  logic [3:0] hex,
  output seg_t       seg
);

  always_comb begin
    seg = en ? SEG_TABLE[hex] : SEG_OFF;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment bank with
// frame-atomic load handshake, blink, leading-zero suppression and blanking.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned NDIG         = 8,
  parameter int unsigned DIV          = 50000,
  parameter int unsigned BLANK        = 16,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input logic           clk,
  input logic           clrn,
  seg_scan_ctrl_if.slave bus
);

  localparam int unsigned PCW = cnt_width(DIV);
  localparam int unsigned IW  = cnt_width(NDIG);
  localparam int unsigned FW  = cnt_width(BLINK_FRAMES);

  localparam logic [PCW-1:0] PC_LAST  = PCW'(DIV - 1);
  localparam logic [PCW-1:0] PC_BLANK = PCW'(BLANK);
  localparam logic [IW-1:0]  IDX_LAST = IW'(NDIG - 1);
  localparam logic [FW-1:0]  FC_LAST  = FW'(BLINK_FRAMES - 1);

  typedef struct packed {
    logic [4*NDIG-1:0] data;
    logic [NDIG-1:0]   en;
    logic [NDIG-1:0]   blink;
    logic              lz;
  } cfg_t;

  cfg_t            cfg_in;
  cfg_t            pend_q, pend_d;
  cfg_t            shad_q, shad_d;
  logic [PCW-1:0]  pc_q, pc_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [FW-1:0]   fc_q, fc_d;
  logic            phase_q, phase_d;
  logic            frame_q, frame_d;
  logic [NDIG-1:0] an_q, an_d;
  seg_t            seg_q, seg_d;
  ld_state_e       ld_q, ld_d;

  logic            pc_wrap;
  logic            boundary;
  logic [3:0]      cur_hex;
  seg_t            dec_seg;
  logic [NDIG-1:0] supp;
  logic            higher_zero;
  logic            digit_zero;
  logic            vis;

  assign cfg_in = '{data: bus.data, en: bus.dig_en, blink: bus.blink, lz: bus.lz_en};

  always_comb begin
    pc_wrap  = (pc_q == PC_LAST);
    boundary = pc_wrap && (idx_q == IDX_LAST);
    pc_d     = pc_wrap ? '0 : pc_q + PCW'(1);
    idx_d    = idx_q;
    if (pc_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
    fc_d    = fc_q;
    phase_d = phase_q;
    if (boundary) begin
      if (fc_q == FC_LAST) begin
        fc_d    = '0;
        phase_d = ~phase_q;
      end else begin
        fc_d = fc_q + FW'(1);
      end
    end
    frame_d = boundary;
  end

  // Handshake FSM: state register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ld_q <= LD_IDLE;
    end else begin
      ld_q <= ld_d;
    end
  end

  // Boundary wins over load: a load on that edge goes straight to shadow
  always_comb begin
    ld_d = ld_q;
    if (boundary) begin
      ld_d = LD_IDLE;
    end else if (bus.load) begin
      ld_d = LD_PEND;
    end
  end

  always_comb begin
    bus.busy = (ld_q == LD_PEND);
  end

  always_comb begin
    pend_d = bus.load ? cfg_in : pend_q;
    shad_d = shad_q;
    if (boundary) begin
      shad_d = bus.load ? cfg_in : pend_q;
    end
  end

  // Digit k is suppressed only if it and every enabled digit above it are zero
  always_comb begin
    cur_hex     = '0;
    supp        = '0;
    higher_zero = 1'b1;
    digit_zero  = 1'b0;
    vis         = 1'b0;
    for (int unsigned i = NDIG - 1; i >= 1; i--) begin
      digit_zero = (shad_q.data[4*i +: 4] == 4'h0);
      supp[i]    = shad_q.lz && digit_zero && higher_zero;
      if (shad_q.en[i] && !digit_zero) begin
        higher_zero = 1'b0;
      end
    end
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (idx_q == IW'(i)) begin
        cur_hex = shad_q.data[4*i +: 4];
        vis     = shad_q.en[i] & ~(shad_q.blink[i] & phase_q) & ~supp[i];
      end
    end
  end

  seg_h u_dec (
    .en  (1'b1),
    .hex (cur_hex),
    .seg (dec_seg)
  );

  always_comb begin
    an_d  = '1;
    seg_d = SEG_OFF;
    if ((pc_q >= PC_BLANK) && vis) begin
      for (int unsigned i = 0; i < NDIG; i++) begin
        if (idx_q == IW'(i)) begin
          an_d[i] = 1'b0;
        end
      end
      seg_d = dec_seg;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pc_q    <= '0;
      idx_q   <= '0;
      fc_q    <= '0;
      phase_q <= 1'b0;
      frame_q <= 1'b0;
      pend_q  <= '0;
      shad_q  <= '0;
      an_q    <= '1;
      seg_q   <= SEG_OFF;
    end else begin
      pc_q    <= pc_d;
      idx_q   <= idx_d;
      fc_q    <= fc_d;
      phase_q <= phase_d;
      frame_q <= frame_d;
      pend_q  <= pend_d;
      shad_q  <= shad_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.an    = an_q;
  assign bus.seg   = seg_q;
  assign bus.frame = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a frame-level reference model predicts
// every output cycle; a negedge monitor pops and compares.
module tb_seg_scan_ctrl;

  localparam int unsigned NDIG         = 4;
  localparam int unsigned DIV          = 8;
  localparam int unsigned BLANK        = 2;
  localparam int unsigned BLINK_FRAMES = 2;
  localparam int unsigned FRAME        = NDIG * DIV;

  logic clk  = 1'b0;
  logic clrn = 1'b1;
  always #5 clk = ~clk;

  logic [4*NDIG-1:0] d_v;
  logic [NDIG-1:0]   en_v, bl_v;
  logic              lz_v, ld_v;

  seg_scan_ctrl_if #(.NDIG(NDIG)) bus ();

  assign bus.data   = d_v;
  assign bus.dig_en = en_v;
  assign bus.blink  = bl_v;
  assign bus.lz_en  = lz_v;
  assign bus.load   = ld_v;

  seg_scan_ctrl #(
    .NDIG         (NDIG),
    .DIV          (DIV),
    .BLANK        (BLANK),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  logic [6:0] seg_ref [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct {
    int unsigned       e;
    logic [4*NDIG-1:0] d;
    logic [NDIG-1:0]   en;
    logic [NDIG-1:0]   bl;
    logic              lz;
  } ld_t;

  typedef struct {
    int unsigned     k;
    logic [NDIG-1:0] an;
    logic [6:0]      seg;
    logic            busy;
    logic            frame;
  } exp_t;

  ld_t         hist[$];
  exp_t        exp_q[$];
  int unsigned k;
  bit          mon_en = 1'b0;
  int          n_chk  = 0;
  int          n_pass = 0;

  function automatic int unsigned digit_of(logic [4*NDIG-1:0] d, int unsigned j);
    return (int'(d) >> (4 * j)) & 15;
  endfunction

  // Frame n shows the newest load sampled at or before edge FRAME*n.
  function automatic exp_t model(int unsigned kk);
    exp_t        r;
    ld_t         cur;
    bit          found = 0;
    bit          supp;
    int unsigned latest = 0;
    int unsigned c      = kk - 1;
    int unsigned n      = c / FRAME;
    int unsigned s      = (c / DIV) % NDIG;
    int unsigned pc     = c % DIV;
    int unsigned phase  = (n / BLINK_FRAMES) % 2;
    foreach (hist[i]) begin
      if (hist[i].e <= FRAME * n) begin
        cur   = hist[i];
        found = 1;
      end
      latest = hist[i].e;
    end
    r.k     = kk;
    r.busy  = (hist.size() > 0) && (latest > FRAME * (kk / FRAME));
    r.frame = (kk % FRAME == 0);
    r.an    = '1;
    r.seg   = 7'h7F;
    if (found && pc >= BLANK) begin
      supp = 0;
      if (s > 0 && cur.lz && digit_of(cur.d, s) == 0) begin
        supp = 1;
        for (int unsigned j = s + 1; j < NDIG; j++)
          if (cur.en[j] && digit_of(cur.d, j) != 0) supp = 0;
      end
      if (cur.en[s] && !(cur.bl[s] && phase == 1) && !supp) begin
        r.an    = '1;
        r.an[s] = 1'b0;
        r.seg   = seg_ref[digit_of(cur.d, s)];
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard_empty: no expected entry at time %0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (bus.an === e.an && bus.seg === e.seg && bus.busy === e.busy && bus.frame === e.frame)
          n_pass++;
        else
          $display("FAIL cycle_%0d: got an=%b seg=%b busy=%b frame=%b, expected an=%b seg=%b busy=%b frame=%b",
                   e.k, bus.an, bus.seg, bus.busy, bus.frame, e.an, e.seg, e.busy, e.frame);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    k++;
    if (ld_v) hist.push_back('{e: k, d: d_v, en: en_v, bl: bl_v, lz: lz_v});
    exp_q.push_back(model(k));
    #1;
    ld_v = 1'b0;
    d_v  = 16'($urandom);
    en_v = 4'($urandom);
    bl_v = 4'($urandom);
    lz_v = 1'($urandom);
  endtask

  task automatic step_to(input int unsigned e);
    while (k + 1 < e) step();
  endtask

  task automatic do_load(input int unsigned e, input logic [15:0] d, input logic [3:0] en,
                         input logic [3:0] bl, input logic lz);
    step_to(e);
    d_v  = d;
    en_v = en;
    bl_v = bl;
    lz_v = lz;
    ld_v = 1'b1;
    step();
  endtask

  task automatic rand_run(input int unsigned cycles);
    repeat (cycles) begin
      step();
      if ($urandom_range(9) == 0) ld_v = 1'b1;
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_an"}, 32'(bus.an), 32'hF);
    chk({tag, "_seg"}, 32'(bus.seg), 32'h7F);
    chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
    chk({tag, "_frame"}, 32'(bus.frame), 32'h0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    clrn = 1'b1;
    k    = 0;
    hist.delete();
    exp_q.delete();
    #1 mon_en = 1'b1;
  endtask

  int unsigned base;

  initial begin
    ld_v = 1'b0; d_v = '0; en_v = '0; bl_v = '0; lz_v = 1'b0; k = 0;
    #2 clrn = 1'b0;
    #1 check_reset("reset_init");
    @(negedge clk);
    release_reset();

    do_load(2 * FRAME + 9,  16'h1A3F, 4'hF, 4'h0, 1'b0);
    do_load(4 * FRAME + 3,  16'h0050, 4'hF, 4'h0, 1'b1);
    do_load(5 * FRAME + 20, 16'h0000, 4'hF, 4'h0, 1'b1);
    do_load(7 * FRAME + 1,  16'h4321, 4'hF, 4'b0001, 1'b0);
    do_load(14 * FRAME + 4, 16'h1111, 4'hF, 4'h0, 1'b0);
    do_load(14 * FRAME + 10, 16'h2222, 4'hF, 4'h0, 1'b0);
    do_load(16 * FRAME,     16'h3333, 4'hF, 4'h0, 1'b0);
    step_to(17 * FRAME);
    rand_run(34 * FRAME);

    // Mid-slot asynchronous reset while digits are lit and a load is pending
    base = (k / FRAME + 1) * FRAME;
    do_load(base + 5, 16'h8888, 4'hF, 4'h0, 1'b0);
    do_load(base + FRAME + 5, 16'h1234, 4'hF, 4'h0, 1'b0);
    step_to(base + FRAME + 14);
    chk("pre_reset_busy", 32'(bus.busy), 32'h1);
    mon_en = 1'b0;
    #2 clrn = 1'b0;
    #1 check_reset("reset_mid");
    exp_q.delete();
    @(negedge clk);
    release_reset();
    rand_run(20 * FRAME);

    @(negedge clk);
    #1 chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
